// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a show-ahead FIFO: one pop per frame, 8N1 LSB first, optional even parity.
// Pop is combinational in IDLE and the start bit follows one cycle later; tx_en low holds off new frames only.
module fifo_uart_tx #(
  parameter int BAUD_DIV  = 10416,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  input  logic       tx_en,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state, state_n;
  logic [15:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        par, par_n;
  logic        tx_n, done_n, bit_end;

  assign fifo_rd = (state == IDLE) & tx_en & ~fifo_empty & ~rst;
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign tx_busy = (state != IDLE);

  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 16'd1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    par_n      = par;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (fifo_rd) begin
          shreg_n = fifo_rdata;
          par_n   = ^fifo_rdata;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          state_n    = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          shreg_n    = {1'b0, shreg[7:1]};
          bit_idx_n  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          state_n    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_n = '0;
          state_n    = IDLE;
          done_n     = 1'b1;
        end
      end
      default: begin
        baud_cnt_n = '0;
        state_n    = IDLE;
      end
    endcase

    // tx is decoded from the next state so the line lines up with the state register
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      par      <= par_n;
      tx       <= tx_n;
      tx_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: dut0 without parity, dut1 with even parity, both at BAUD_DIV=4.
// Stimulus queues hand-computed frames; one monitor decodes the lines and scores them.
module tb_fifo_uart_tx;

  localparam int BAUD = 4;

  typedef struct {
    logic [10:0] bits;
    int          spacing;
    bit          abort;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0;
  logic [7:0]  fifo_mem [2][16];
  logic [3:0]  wr_ptr [2] = '{4'd0, 4'd0};
  logic [3:0]  rd_ptr [2] = '{4'd0, 4'd0};
  wire  [1:0]  fifo_empty_w, fifo_rd_w, tx_w, busy_w, done_w;
  wire  [7:0]  rdata0, rdata1;
  exp_t        exp_mem [2][16];
  int          exp_wr [2] = '{0, 0};
  int          exp_rd [2] = '{0, 0};
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          end_req = 1'b0;

  assign fifo_empty_w = {rd_ptr[1] == wr_ptr[1], rd_ptr[0] == wr_ptr[0]};
  assign rdata0 = fifo_mem[0][rd_ptr[0]];
  assign rdata1 = fifo_mem[1][rd_ptr[1]];

  fifo_uart_tx #(.BAUD_DIV(BAUD), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty_w[0]), .fifo_rdata(rdata0),
    .fifo_rd(fifo_rd_w[0]), .tx_en(tx_en), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );

  fifo_uart_tx #(.BAUD_DIV(BAUD), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty_w[1]), .fifo_rdata(rdata1),
    .fifo_rd(fifo_rd_w[1]), .tx_en(tx_en), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );

  always #5 clk = ~clk;

  // FIFO model: pop on fifo_rd, visible to the DUT after the edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_w[0]) rd_ptr[0] <= rd_ptr[0] + 4'd1;
    if (fifo_rd_w[1]) rd_ptr[1] <= rd_ptr[1] + 4'd1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int d, input logic [7:0] b);
    fifo_mem[d][wr_ptr[d]] = b;
    wr_ptr[d] = wr_ptr[d] + 4'd1;
  endtask

  // bits[k] is the k-th bit on the line (start bit first); spacing 0 means unchecked
  task automatic exp_frame(input int d, input logic [10:0] bits, input int spacing, input bit abort);
    exp_mem[d][exp_wr[d] % 16] = '{bits, spacing, abort};
    exp_wr[d] = exp_wr[d] + 1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks = n_checks + 1;
    if (act != req) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic compare_frame(input int d, input bit aborted, input logic [10:0] bits,
                               input bit varied, input int spacing);
    exp_t e;
    chk("frame_expected", int'(exp_wr[d] != exp_rd[d]), 1);
    if (exp_wr[d] == exp_rd[d]) return;
    e = exp_mem[d][exp_rd[d] % 16];
    exp_rd[d] = exp_rd[d] + 1;
    chk("frame_abort", int'(aborted), int'(e.abort));
    if (!e.abort && !aborted) begin
      chk("frame_bits", int'(bits), int'(e.bits));
      chk("bit_steady", int'(varied), 0);
      if (e.spacing != 0) chk("rd_spacing", spacing, e.spacing);
    end
  endtask

  initial begin
    push(0, 8'hA5);
    tick(2);
    rst = 1'b0;
    tick(3);
    exp_frame(0, 11'b01101001010, 0, 1'b0);
    tx_en = 1'b1;
    tick(50);

    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
    exp_frame(0, 11'b01000000000, 0, 1'b0);
    exp_frame(0, 11'b01111111110, 41, 1'b0);
    exp_frame(0, 11'b01010101010, 41, 1'b0);
    tick(140);

    push(1, 8'h07); push(1, 8'hC3);
    exp_frame(1, 11'b11000001110, 0, 1'b0);
    exp_frame(1, 11'b10110000110, 45, 1'b0);
    tick(110);

    // reset lands in DATA bit 3; the 0x99 waiting behind it must not be popped during reset
    push(0, 8'h3C);
    exp_frame(0, 11'b0, 0, 1'b1);
    tick(18);
    rst = 1'b1;
    push(0, 8'h99);
    exp_frame(0, 11'b01100110010, 0, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(60);

    push(0, 8'h81); push(0, 8'h42);
    exp_frame(0, 11'b01100000010, 0, 1'b0);
    tick(10);
    tx_en = 1'b0;
    tick(140);
    exp_frame(0, 11'b01010000100, 0, 1'b0);
    tx_en = 1'b1;
    tick(60);
    end_req = 1'b1;
  end

  initial begin : monitor
    int          st [2];
    int          bi [2];
    int          sb [2];
    logic        cur [2];
    logic [10:0] fb [2];
    bit          bad [2];
    int          last_rd [2];
    int          spc [2];
    bit          prev_rst;
    bit          go;
    int          nb;
    logic        t, b, dn, r, emp, er;
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; bi[d] = 0; sb[d] = 0; cur[d] = 1'b1; fb[d] = '0;
      bad[d] = 1'b0; last_rd[d] = -1; spc[d] = 0;
    end
    prev_rst = 1'b0;
    forever begin
      @(negedge clk);
      if (end_req || cyc > 4000) begin
        if (!end_req) begin
          n_errors = n_errors + 1;
          $display("FAIL watchdog: reached cycle %0d, required end before 4000", cyc);
        end
        for (int d = 0; d < 2; d++) chk("outstanding_frames", exp_wr[d] - exp_rd[d], 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
      for (int d = 0; d < 2; d++) begin
        nb  = (d == 0) ? 10 : 11;
        t   = tx_w[d];
        b   = busy_w[d];
        dn  = done_w[d];
        r   = fifo_rd_w[d];
        emp = fifo_empty_w[d];
        er  = !rst && tx_en && !emp && (st[d] != 1);
        chk("fifo_rd", int'(r), int'(er));
        if (prev_rst) begin
          chk("reset_tx", int'(t), 1);
          chk("reset_busy", int'(b), 0);
          chk("reset_done", int'(dn), 0);
        end
        go = 1'b0;
        case (st[d])
          0: begin
            if (!rst) begin
              chk("idle_tx", int'(t), 1);
              chk("idle_done", int'(dn), 0);
            end
            go = r;
          end
          1: begin
            if (rst) begin
              compare_frame(d, 1'b1, fb[d], bad[d], spc[d]);
              st[d] = 0;
            end else begin
              chk("busy_in_frame", int'(b), 1);
              chk("done_in_frame", int'(dn), 0);
              if (sb[d] == 0) cur[d] = t;
              else if (t != cur[d]) bad[d] = 1'b1;
              sb[d] = sb[d] + 1;
              if (sb[d] == BAUD) begin
                fb[d][bi[d]] = cur[d];
                bi[d] = bi[d] + 1;
                sb[d] = 0;
                if (bi[d] == nb) st[d] = 2;
              end
            end
          end
          2: begin
            chk("done_pulse", int'(dn), 1);
            chk("busy_after_stop", int'(b), 0);
            chk("tx_after_stop", int'(t), 1);
            compare_frame(d, 1'b0, fb[d], bad[d], spc[d]);
            st[d] = 0;
            go = r;
          end
          default: st[d] = 0;
        endcase
        if (go) begin
          st[d] = 1; bi[d] = 0; sb[d] = 0; fb[d] = '0; bad[d] = 1'b0;
          spc[d] = (last_rd[d] < 0) ? 0 : cyc - last_rd[d];
          last_rd[d] = cyc;
        end
      end
      prev_rst = rst;
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter BAUD_DIV, default 10416, giving clocks per UART bit (legal range 2..65535).
REQ-002 The block SHALL have parameter PARITY_EN, default 0; 1 inserts an even-parity bit.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fifo_empty  input  1  high when the upstream FIFO holds no data.
REQ-006 fifo_rdata  input  8  head-of-FIFO byte, valid whenever fifo_empty is low.
REQ-007 fifo_rd  output  1  one-cycle pop strobe to the FIFO.
REQ-008 tx_en  input  1  high permits new frames to start.
REQ-009 tx  output  1  serial line, registered, idle high.
REQ-010 tx_busy  output  1  high while a frame is in progress.
REQ-011 tx_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is entered only when PARITY_EN=1.
REQ-013 fifo_rd SHALL be combinational: fifo_rd = (state==IDLE) & tx_en & ~fifo_empty & ~rst.
REQ-014 The edge at which fifo_rd is high SHALL latch fifo_rdata into the shift register, compute even parity (XOR of the 8 bits), and move IDLE->START.
REQ-015 fifo_rd SHALL never be high for two consecutive cycles, nor when fifo_empty is high.
REQ-016 Each of START, each DATA bit, PARITY and STOP SHALL hold tx constant for exactly BAUD_DIV cycles, timed by a baud counter that counts 0..BAUD_DIV-1 and restarts at every bit boundary.
REQ-017 tx SHALL be 0 in START, shift-register bit 0 in DATA (LSB first, 8 bits, 3-bit index), the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-018 tx SHALL change on the edge after the state/bit change (one register stage); the first start-bit cycle is the cycle after fifo_rd.
REQ-019 Transitions: DATA->PARITY (PARITY_EN=1) or DATA->STOP after bit index 7 completes; PARITY->STOP; STOP->IDLE after BAUD_DIV cycles.
REQ-020 tx_done SHALL be high for exactly the single cycle following the STOP->IDLE edge.
REQ-021 tx_busy SHALL be high in every state except IDLE.
REQ-022 Back-to-back: the block SHALL spend exactly one cycle in IDLE between frames, giving a fifo_rd spacing of (10+PARITY_EN)*BAUD_DIV+1 cycles.
REQ-023 tx_en low SHALL NOT abort a frame in progress; it only blocks the IDLE->START transition.
REQ-024 Changes on fifo_empty or fifo_rdata after the latch edge SHALL NOT affect the frame in progress.

Reset
REQ-025 While rst is high at a rising edge, the block SHALL set state=IDLE, tx=1, tx_busy=0, tx_done=0, and clear the baud counter, bit index, shift register and parity bit.
REQ-026 rst high SHALL force fifo_rd=0 in the same cycle, so no FIFO entry is consumed during reset.
REQ-027 Reset mid-frame SHALL abandon the frame: tx=1 from the next edge, no tx_done pulse, and the byte is lost.

Verification (BAUD_DIV=4 unless stated)
REQ-028 Reset: rst=1 for 2 cycles with fifo_empty=0 -> fifo_rd=0 throughout; afterwards tx=1, tx_busy=0, tx_done=0.
REQ-029 Single byte 0xA5, PARITY_EN=0 -> one fifo_rd pulse; tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles; tx_done pulses once, 40 cycles after the first start-bit cycle.
REQ-030 Bytes 0x00, 0xFF, 0x55 queued -> exactly 3 fifo_rd pulses, spaced 41 cycles; line shows the three correct LSB-first frames.
REQ-031 PARITY_EN=1, byte 0x07 -> 11-bit frame 0,1,1,1,0,0,0,0,0,1(parity),1; fifo_rd spacing with queued data is 45 cycles.
REQ-032 Reset asserted during DATA bit 3 of 0x3C -> tx=1 on the next edge; tx_busy=0; no tx_done; no fifo_rd until rst deasserts.
REQ-033 tx_en dropped mid-frame with the FIFO non-empty -> the current frame completes with tx_done; then no fifo_rd and tx=1 for 100 cycles; raising tx_en -> fifo_rd in the same cycle.
